semaforo_head: RTL
==================

// Module: semaforo_head
// PURPOSE
//  Lamp-side endpoint of the intersection controller's change/set interface: one instance per signal head.
//  Consumes the controller's one-cycle change pulses and its initial-colour set level.
//  Sequences its own lamp colour and drives the lamp outputs.
//  Returns red_check (head is red and settled) to the controller.
//  Flashes while the intersection is disabled; guards against a stuck yellow.
// PARAMETERS
//  HAS_YELLOW      1      1 = vehicle head (G->Y->R); 0 = pedestrian head (G->R, no yellow lamp)
//  BLINK_HALF_CYC  5000   CLK cycles per half-period of disabled-mode flash (0.5 s at 10 kHz)
//  RED_SETTLE_CYC  10000  consecutive RED cycles before red_check asserts (1 s)
//  YELLOW_MAX_CYC  50000  max YELLOW dwell before forced RED + fault (5 s)
// PORTS
//  CLK            in   1  10 kHz system clock
//  reset_general  in   1  synchronous, active-high reset
//  enable_general in   1  1 = run; 0 = disabled flash mode
//  change         in   1  step request from controller; acts on rising edge only
//  set_init       in   1  initial colour loaded on enable: 1 = GREEN, 0 = RED
//  lamp_red       out  1  red lamp drive
//  lamp_yellow    out  1  yellow lamp drive (held 0 when HAS_YELLOW = 0)
//  lamp_green     out  1  green lamp drive
//  color          out  2  current colour code (semaforo_pkg::color_t)
//  red_check      out  1  RED held >= RED_SETTLE_CYC cycles
//  fault          out  1  sticky: yellow timeout occurred
// BEHAVIOUR
//  States: BLINK, GREEN, YELLOW, RED. reset_general has priority over every other input.
//  Reset values:
//   - state = BLINK; blink phase = 0
//   - all lamps = 0; color = OFF; red_check = 0; fault = 0
//   - dwell counter = 0; change edge register = 0
//  BLINK:
//   - Lamps toggle every BLINK_HALF_CYC cycles; phase 0 = dark.
//   - Flashing lamp is yellow when HAS_YELLOW = 1, red when HAS_YELLOW = 0.
//   - change is ignored.
//  Leaving BLINK:
//   - First cycle with enable_general = 1: set_init selects the next state, GREEN (1) or RED (0).
//   - A change edge in that same cycle is discarded.
//  Any state with enable_general = 0: next state is BLINK; dwell counter clears; fault is unchanged.
//  Change step, rising edge of change (change & ~change_q):
//   - GREEN -> YELLOW, or GREEN -> RED when HAS_YELLOW = 0
//   - YELLOW -> RED
//   - RED -> GREEN
//   - A change held high steps exactly once.
//  Latency: change high in cycle k -> new state and lamps visible after the edge that ends cycle k.
//   Lamps and color are decoded combinationally from the state register.
//  Dwell counter:
//   - Clears on every state change; counts up in RED and YELLOW; saturates at its maximum value.
//   - red_check = (state == RED) && (dwell >= RED_SETTLE_CYC - 1).
//   - red_check deasserts on the same edge that leaves RED.
//  Yellow watchdog:
//   - YELLOW with dwell == YELLOW_MAX_CYC - 1 and no change edge -> forced RED; fault <= 1.
//   - A change edge in that same cycle -> RED with no fault.
//  fault clears only on reset_general.
//  Exactly one lamp is on outside BLINK; never two lamps on in any state.
// STRUCTURE
//  Package semaforo_pkg:
//   - color_t enum, 2-bit: OFF = 0, RED = 1, YELLOW = 2, GREEN = 3
//   - head state enum
//   - default timing constants (CLK_HZ = 10000)
//  Sub-module blink_divider: counter with sync clear; emits a one-cycle tick every BLINK_HALF_CYC cycles.
//   Cleared whenever state != BLINK.
//  Top level holds the edge detector, the state register, the dwell counter and the fault flag.
// TESTING (sim parameters: BLINK_HALF_CYC = 3, RED_SETTLE_CYC = 4, YELLOW_MAX_CYC = 8)
//  1. Reset, enable = 0 for 12 cycles -> lamp_yellow toggles every 3 cycles; red/green = 0; change pulses ignored.
//  2. set_init = 1, enable 0->1 -> next cycle color = GREEN; 3 one-cycle change pulses -> YELLOW, RED, GREEN.
//     red_check = 1 only after the 4th RED cycle.
//  3. change held high 10 cycles in GREEN -> exactly one step to YELLOW.
//  4. YELLOW with no change for 8 cycles -> forced RED, fault = 1.
//     fault stays 1 through further cycles and until reset_general.
//  5. HAS_YELLOW = 0, set_init = 0:
//     - enable -> RED; change -> GREEN; change -> RED; lamp_yellow never 1
//     - disabled flash uses lamp_red
//  6. enable_general dropped while in RED with red_check = 1 -> next cycle BLINK, red_check = 0.
//     reset_general asserted together with a change edge -> BLINK, all outputs at reset values.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the signal-head endpoint.
package semaforo_pkg;

    // Colour code driven on the color output.
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        GREEN  = 2'd3
    } color_t;

    // Sequencer state of one signal head.
    typedef enum logic [1:0] {
        ST_BLINK,
        ST_GREEN,
        ST_YELLOW,
        ST_RED
    } head_state_t;

    // Default timing, expressed against the 10 kHz system clock.
    localparam int CLK_HZ             = 10000;
    localparam int DEF_BLINK_HALF_CYC = CLK_HZ / 2;   // 0.5 s
    localparam int DEF_RED_SETTLE_CYC = CLK_HZ;       // 1 s
    localparam int DEF_YELLOW_MAX_CYC = 5 * CLK_HZ;   // 5 s

    // Colour reported for each state; the flashing mode reports OFF.
    function automatic color_t state_color(input head_state_t s);
        case (s)
            ST_GREEN:  return GREEN;
            ST_YELLOW: return YELLOW;
            ST_RED:    return RED;
            default:   return OFF;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_blink_divider.sv
// Flash-rate divider: one-cycle tick every HALF_CYC cycles, restartable.
module blink_divider #(
    parameter int HALF_CYC = 5000
) (
    input  logic CLK,
    input  logic reset_general,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] count;

    // Free-running modulo counter, held at zero while cleared.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the values from before the edge, independent of block order.
        if (reset_general || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !reset_general && !clear && (count == LAST);

endmodule

// File: rtl/semaforo_head.sv
// Lamp-side endpoint of the intersection change/set interface (one per head).
module semaforo_head
    import semaforo_pkg::*;
#(
    parameter bit HAS_YELLOW     = 1'b1,
    parameter int BLINK_HALF_CYC = DEF_BLINK_HALF_CYC,
    parameter int RED_SETTLE_CYC = DEF_RED_SETTLE_CYC,
    parameter int YELLOW_MAX_CYC = DEF_YELLOW_MAX_CYC
) (
    input  logic   CLK,
    input  logic   reset_general,
    input  logic   enable_general,
    input  logic   change,
    input  logic   set_init,
    output logic   lamp_red,
    output logic   lamp_yellow,
    output logic   lamp_green,
    output color_t color,
    output logic   red_check,
    output logic   fault
);

    // Dwell counter only needs to reach the larger of the two thresholds.
    localparam int DWELL_MAX = (RED_SETTLE_CYC > YELLOW_MAX_CYC) ? RED_SETTLE_CYC : YELLOW_MAX_CYC;
    localparam int DW        = $clog2(DWELL_MAX + 1);

    localparam logic [DW-1:0] RED_LAST    = DW'(RED_SETTLE_CYC - 1);
    localparam logic [DW-1:0] YELLOW_LAST = DW'(YELLOW_MAX_CYC - 1);

    head_state_t   state;
    head_state_t   state_next;
    logic          change_q;
    logic          change_edge;
    logic [DW-1:0] dwell;
    logic          yellow_timeout;
    logic          blink_tick;
    logic          blink_phase;

    assign change_edge = change && !change_q;

    blink_divider #(
        .HALF_CYC (BLINK_HALF_CYC)
    ) u_blink_divider (
        .CLK           (CLK),
        .reset_general (reset_general),
        .clear         (state != ST_BLINK),
        .tick          (blink_tick)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (reset_general) begin
            state <= ST_BLINK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state rules: disable wins, then enable-time load, then change steps and the yellow watchdog.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        state_next     = state;
        yellow_timeout = 1'b0;
        if (!enable_general) begin
            state_next = ST_BLINK;
        end else begin
            case (state)
                ST_BLINK: begin
                    // A change edge arriving with the enable is deliberately dropped.
                    state_next = set_init ? ST_GREEN : ST_RED;
                end
                ST_GREEN: begin
                    if (change_edge) begin
                        state_next = HAS_YELLOW ? ST_YELLOW : ST_RED;
                    end
                end
                ST_YELLOW: begin
                    if (change_edge) begin
                        state_next = ST_RED;
                    end else if (dwell == YELLOW_LAST) begin
                        state_next     = ST_RED;
                        yellow_timeout = 1'b1;
                    end
                end
                ST_RED: begin
                    if (change_edge) begin
                        state_next = ST_GREEN;
                    end
                end
                default: state_next = ST_BLINK;
            endcase
        end
    end

    // Lamp and colour decode straight from the state register.
    always_comb begin
        lamp_red    = 1'b0;
        lamp_yellow = 1'b0;
        lamp_green  = 1'b0;
        color       = state_color(state);
        red_check   = (state == ST_RED) && (dwell >= RED_LAST);
        case (state)
            ST_BLINK: begin
                if (HAS_YELLOW) begin
                    lamp_yellow = blink_phase;
                end else begin
                    lamp_red = blink_phase;
                end
            end
            ST_GREEN:  lamp_green  = 1'b1;
            ST_YELLOW: lamp_yellow = HAS_YELLOW;
            ST_RED:    lamp_red    = 1'b1;
            default:   ;
        endcase
    end

    // Previous change level, so a held request steps only once.
    always_ff @(posedge CLK) begin
        if (reset_general) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change;
        end
    end

    // Time spent in the current colour; counts only in RED/YELLOW and saturates.
    always_ff @(posedge CLK) begin
        if (reset_general) begin
            dwell <= '0;
        end else if (!enable_general || (state_next != state)) begin
            dwell <= '0;
        end else if (((state == ST_RED) || (state == ST_YELLOW)) && (dwell != '1)) begin
            dwell <= dwell + 1'b1;
        end
    end

    // Sticky stuck-yellow flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (reset_general) begin
            fault <= 1'b0;
        end else if (yellow_timeout) begin
            fault <= 1'b1;
        end
    end

    // Flash phase; restarts dark every time the head re-enters BLINK.
    always_ff @(posedge CLK) begin
        if (reset_general || (state != ST_BLINK)) begin
            blink_phase <= 1'b0;
        end else if (blink_tick) begin
            blink_phase <= !blink_phase;
        end
    end

endmodule
